mac_in3_pair_accum_ctrl: RTL and testbench

MAC_IN3_PAIR_ACCUM_CTRL -- requirements
Module: mac_in3_pair_accum_ctrl

---
 rtl/mac_in3_pair_accum_ctrl.sv | 129 ++++++++++++
 tb/tb_mac_in3_pair_accum_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mac_in3_pair_accum_ctrl.sv
// mac_in3_pair_accum_ctrl
// Reduction controller for packed INT16 beats. Each beat carries eight signed
// halfwords. Each adjacent pair is summed into one of four INT32 lanes, and the
// lanes accumulate over a configured number of beats. The finished result is
// then offered through a valid/ready handshake. An abort cancels the reduction
// from any busy state.
module mac_in3_pair_accum_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic [LEN_W-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      acc_q [4];
    logic [31:0]      acc_d [4];
    logic [31:0]      lane_sum [4];
    logic             beat_acc;
    logic             final_beat;

    // Per-lane pair sum of the incoming beat; the lanes also drive out_data straight from the accumulators.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_sum[gi] = {{16{in_data[32*gi+15]}}, in_data[32*gi+15 -: 16]}
                                + {{16{in_data[32*gi+31]}}, in_data[32*gi+31 -: 16]};
            assign out_data[32*gi +: 32] = acc_q[gi];
        end
    endgenerate

    // A length of zero wraps so that len-1 becomes all ones, which gives 2^LEN_W beats.
    assign final_beat = (cnt_q == (len_q - LEN_W'(1)));
    assign beat_acc   = in_valid && (state_q == ACCUM);
    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign beat_cnt   = cnt_q;

    // Next-state logic, accumulation and abort handling. Abort takes priority over beats and handshakes.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 4; i++) begin
            acc_d[i] = acc_q[i];
        end
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = '0;
                    end
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    cnt_d   = '0;
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = '0;
                    end
                    state_d = IDLE;
                end else if (beat_acc) begin
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = acc_q[i] + lane_sum[i];
                    end
                    cnt_d = cnt_q + LEN_W'(1);
                    if (final_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    cnt_d   = '0;
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = '0;
                    end
                    state_d = IDLE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured length, beat counter and accumulators; an asynchronous reset clears all of them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mac_in3_pair_accum_ctrl.sv
// Directed testbench for mac_in3_pair_accum_ctrl.
// Inputs change on the falling edge and outputs are checked on the falling edge.
module tb_mac_in3_pair_accum_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   cfg_len = 8'd0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
    logic [7:0]   beat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mac_in3_pair_accum_ctrl #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Called at a falling edge. Returns at the falling edge after the start was sampled.
    task automatic do_start(input logic [7:0] len);
        start = 1'b1; cfg_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a falling edge. Returns at the falling edge after the beat was presented for one cycle.
    task automatic send_beat(input logic [127:0] d);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (out_data !== 128'd0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_cmp++; if (beat_cnt !== 8'd0) begin n_err++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1; abort = 1'b1; cfg_len = 8'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_start_idle got busy=%0b exp=0", busy); end
        $display("test_reset: done");
    endtask

    task automatic test_neg_ones();
        do_start(8'd1);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL neg_in_ready got=%0b exp=1", in_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL neg_busy got=%0b exp=1", busy); end
        send_beat({8{16'hFFFF}});
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL neg_out_valid got=%0b exp=1", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL neg_done_in_ready got=%0b exp=0", in_ready); end
        n_cmp++; if (out_data !== {4{32'hFFFFFFFE}}) begin n_err++; $display("FAIL neg_out_data got=%h exp=%h", out_data, {4{32'hFFFFFFFE}}); end
        n_cmp++; if (beat_cnt !== 8'd1) begin n_err++; $display("FAIL neg_beat_cnt got=%0d exp=1", beat_cnt); end
        do_handshake();
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL neg_after_hs got busy=%0b ov=%0b exp 0/0", busy, out_valid); end
        $display("test_neg_ones: done");
    endtask

    task automatic test_gapped();
        do_start(8'd2);
        send_beat({8{16'h7FFF}});
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b1 || beat_cnt !== 8'd1 || out_valid !== 1'b0)
                begin n_err++; $display("FAIL gap_hold got rdy=%0b cnt=%0d ov=%0b exp 1/1/0", in_ready, beat_cnt, out_valid); end
            @(negedge clk);
        end
        send_beat({8{16'h7FFF}});
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_out_valid got=%0b exp=1", out_valid); end
        n_cmp++; if (out_data !== {4{32'h0001FFFC}}) begin n_err++; $display("FAIL gap_out_data got=%h exp=%h", out_data, {4{32'h0001FFFC}}); end
        do_handshake();
        $display("test_gapped: done");
    endtask

    task automatic test_lane_order_and_hold();
        logic [127:0] exp_d;
        exp_d = {32'h0000000F, 32'h0000000B, 32'h00000007, 32'h00000003};
        do_start(8'd1);
        send_beat({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL lane_out_data got=%h exp=%h", out_data, exp_d); end
        start = 1'b1; cfg_len = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (out_data !== exp_d || in_ready !== 1'b0 || out_valid !== 1'b1 || beat_cnt !== 8'd1)
                begin n_err++; $display("FAIL hold_cycle%0d got d=%h rdy=%0b ov=%0b cnt=%0d", i, out_data, in_ready, out_valid, beat_cnt); end
        end
        start = 1'b0;
        do_handshake();
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL hold_after_hs got busy=%0b ov=%0b exp 0/0", busy, out_valid); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_start_ignored got busy=%0b exp=0", busy); end
        $display("test_lane_order_and_hold: done");
    endtask

    task automatic test_abort();
        do_start(8'd4);
        send_beat({8{16'h0001}});
        send_beat({8{16'h0001}});
        in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || beat_cnt !== 8'd0) begin n_err++; $display("FAIL abort3_state got busy=%0b cnt=%0d exp 0/0", busy, beat_cnt); end
        n_cmp++; if (out_data !== 128'd0) begin n_err++; $display("FAIL abort3_acc got=%h exp=0", out_data); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort3_no_result got ov=%0b exp=0", out_valid); end
            @(negedge clk);
        end
        do_start(8'd1);
        in_valid = 1'b1; abort = 1'b1; in_data = {8{16'h0003}};
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL abort_final got busy=%0b ov=%0b exp 0/0", busy, out_valid); end
        do_start(8'd1);
        send_beat({8{16'h0003}});
        out_ready = 1'b1; abort = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || out_data !== 128'd0) begin n_err++; $display("FAIL abort_hs got busy=%0b d=%h exp 0/0", busy, out_data); end
        $display("test_abort: done");
    endtask

    task automatic test_async_reset_full_len();
        do_start(8'd3);
        send_beat({8{16'h0005}});
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL areset_ctrl got busy=%0b rdy=%0b ov=%0b exp 0", busy, in_ready, out_valid); end
        n_cmp++; if (out_data !== 128'd0 || beat_cnt !== 8'd0)
            begin n_err++; $display("FAIL areset_data got d=%h cnt=%0d exp 0", out_data, beat_cnt); end
        start = 1'b1; cfg_len = 8'd0;
        #1 rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || beat_cnt !== 8'd0) begin n_err++; $display("FAIL areset_first_start got busy=%0b cnt=%0d exp 1/0", busy, beat_cnt); end
        in_valid = 1'b1; in_data = {8{16'h0001}};
        repeat (255) @(negedge clk);
        n_cmp++; if (beat_cnt !== 8'd255 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL len0_255 got cnt=%0d ov=%0b rdy=%0b exp 255/0/1", beat_cnt, out_valid, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || beat_cnt !== 8'd0) begin n_err++; $display("FAIL len0_256 got ov=%0b cnt=%0d exp 1/0", out_valid, beat_cnt); end
        n_cmp++; if (out_data !== {4{32'h00000200}}) begin n_err++; $display("FAIL len0_data got=%h exp=%h", out_data, {4{32'h00000200}}); end
        do_handshake();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0_idle got busy=%0b exp=0", busy); end
        $display("test_async_reset_full_len: done");
    endtask

    initial begin
        test_reset();
        test_neg_ones();
        test_gapped();
        test_lane_order_and_hold();
        test_abort();
        test_async_reset_full_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
